// File: rtl/sdf_acc_nflow.sv
// Multi-flow SDF accumulator actor: N_FLOWS input FIFOs share one adder and
// one tagged output FIFO. Each flow keeps its own windowed running sum.
module sdf_acc_nflow #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned N_FLOWS      = 4,
  parameter int unsigned TAG_W        = 2,
  parameter int unsigned ACC_LEN      = 4,
  parameter int unsigned CNT_W        = 2,
  parameter bit          RR_MODE      = 1'b0,
  parameter bit          EMIT_PARTIAL = 1'b1
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic [N_FLOWS*DATA_W-1:0]  in_data,
  input  logic [N_FLOWS-1:0]         in_empty,
  output logic [N_FLOWS-1:0]         in_read,
  input  logic                       full,
  output logic                       wr,
  output logic [TAG_W+DATA_W-1:0]    out_data,
  output logic                       out_last
);

  localparam int unsigned IDX_W = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1;

  logic [DATA_W-1:0] acc  [N_FLOWS];
  logic [CNT_W-1:0]  cnt  [N_FLOWS];
  logic [DATA_W-1:0] head [N_FLOWS];
  logic [TAG_W-1:0]  rr_ptr;

  logic [N_FLOWS-1:0] elig;
  logic               fire;
  logic [IDX_W-1:0]   g_idx;
  logic [DATA_W-1:0]  sum;
  logic               last;

  always_comb begin
    for (int unsigned i = 0; i < N_FLOWS; i++) begin
      head[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Reset and backpressure both suppress every request, so no token can be
  // consumed without a write slot.
  assign elig = (rst || full) ? '0 : ~in_empty;

  always_comb begin
    fire  = 1'b0;
    g_idx = '0;
    if (RR_MODE) begin
      for (int unsigned k = 1; k <= N_FLOWS; k++) begin
        int unsigned idx;
        idx = (32'(rr_ptr) + k) % N_FLOWS;
        if (!fire && elig[idx]) begin
          fire  = 1'b1;
          g_idx = IDX_W'(idx);
        end
      end
    end else begin
      // Ascending scan: the last eligible index seen wins.
      for (int unsigned i = 0; i < N_FLOWS; i++) begin
        if (elig[i]) begin
          fire  = 1'b1;
          g_idx = IDX_W'(i);
        end
      end
    end
  end

  assign sum  = acc[g_idx] + head[g_idx];
  assign last = (cnt[g_idx] == CNT_W'(ACC_LEN - 1));

  always_comb begin
    in_read  = '0;
    wr       = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    if (fire) begin
      in_read[g_idx] = 1'b1;
      wr             = EMIT_PARTIAL ? 1'b1 : last;
      out_data       = {TAG_W'(g_idx), sum};
      out_last       = last;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_FLOWS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      rr_ptr <= TAG_W'(N_FLOWS - 1);
    end else if (fire) begin
      if (last) begin
        acc[g_idx] <= '0;
        cnt[g_idx] <= '0;
      end else begin
        acc[g_idx] <= sum;
        cnt[g_idx] <= cnt[g_idx] + 1'b1;
      end
      if (RR_MODE) rr_ptr <= TAG_W'(g_idx);
    end
  end

endmodule
